mult_div_unit: RTL and testbench

//  Multi-cycle MIPS multiply/divide unit in the EX stage, alongside the ALU. Owns the HI/LO

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_addsub.sv | 65 ++++++
 rtl/mult_div_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default width.
// No logic; pure type and constant declarations.
// Imported by the top and its datapath sub-module.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    // Encoding of the op port
    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_addsub.sv
// Add/subtract of width W built from chained 4-bit carry-lookahead cells.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mdu_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    // Pad to a whole number of 4-bit groups; pad bits are zero, so they kill the carry
    localparam int NG = (W + 3) / 4;
    localparam int NP = NG * 4;

    logic [W-1:0]  w_bx;
    logic [NP-1:0] w_a;
    logic [NP-1:0] w_b;
    logic [NP-1:0] w_g;
    logic [NP-1:0] w_p;
    logic [NP:0]   w_c;
    logic          w_unused;

    // Subtract is a + ~b + 1; the +1 enters as the chain carry-in
    assign w_bx   = i_sub ? ~i_b : i_b;
    assign w_a    = NP'(i_a);
    assign w_b    = NP'(w_bx);
    assign w_g    = w_a & w_b;
    assign w_p    = w_a ^ w_b;
    assign w_c[0] = i_sub;

    for (genvar gi = 0; gi < NG; gi++) begin : g_cla
        localparam int B = 4 * gi;
        logic [3:0] w_gi;
        logic [3:0] w_pi;
        logic       w_ci;
        logic       w_gg;
        logic       w_gp;

        assign w_gi = w_g[B+3:B];
        assign w_pi = w_p[B+3:B];
        assign w_ci = w_c[B];

        // Lookahead carries inside the cell, all from the cell carry-in
        assign w_c[B+1] = w_gi[0] | (w_pi[0] & w_ci);
        assign w_c[B+2] = w_gi[1] | (w_pi[1] & w_gi[0]) | (w_pi[1] & w_pi[0] & w_ci);
        assign w_c[B+3] = w_gi[2] | (w_pi[2] & w_gi[1]) | (w_pi[2] & w_pi[1] & w_gi[0])
                        | (w_pi[2] & w_pi[1] & w_pi[0] & w_ci);

        // Group generate/propagate feed the next cell
        assign w_gg = w_gi[3] | (w_pi[3] & w_gi[2]) | (w_pi[3] & w_pi[2] & w_gi[1])
                    | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);
        assign w_gp = &w_pi;
        assign w_c[B+4] = w_gg | (w_gp & w_ci);
    end

    assign o_sum  = w_p[W-1:0] ^ w_c[W-1:0];
    assign o_cout = w_c[W];

    // Carries and propagates above bit W only exist because of group padding
    assign w_unused = (^w_c) ^ (^w_p);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Latency: WIDTH+1 cycles from accepted start to done pulse (33 for WIDTH=32).
// Backpressure: busy high outside IDLE; start and moves while busy are dropped, not queued.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdu_state_e       r_state;
    mdu_state_e       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;      // partial product high half / partial remainder
    logic [WIDTH-1:0] r_q;        // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] r_opb;      // |multiplicand| or |divisor|
    logic             r_is_div;
    logic             r_neg_q;    // negate product or quotient at fixup
    logic             r_neg_r;    // remainder takes the dividend's sign
    logic             r_dbz_pend; // divide with zero divisor in flight
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic             w_launch;
    logic             w_commit;
    logic             w_move_ok;
    logic             w_is_div_in;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_add_a;
    logic [WIDTH:0]   w_add_b;
    logic [WIDTH:0]   w_sum;
    logic             w_cout;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand conditioning at launch: signed ops work on magnitudes
    assign w_is_div_in = op[1];
    assign w_a_neg     = op[0] & a[WIDTH-1];
    assign w_b_neg     = op[0] & b[WIDTH-1];
    assign w_abs_a     = w_a_neg ? -a : a;
    assign w_abs_b     = w_b_neg ? -b : b;

    // Adder operands: shift-add for multiply, trial subtract of shifted remainder for divide
    always_comb begin
        w_add_a = {1'b0, r_acc};
        w_add_b = '0;
        if (r_is_div) begin
            w_add_a = {r_acc, r_q[WIDTH-1]};
            w_add_b = {1'b0, r_opb};
        end else if (r_q[0]) begin
            w_add_b = {1'b0, r_opb};
        end
    end

    mdu_addsub #(.W(WIDTH + 1)) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_sub  (r_is_div),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Sign fixup of the raw magnitudes; zero divisor forces an all-ones quotient
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_dbz_pend ? '1 : (r_neg_q ? -r_q : r_q);
    assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state and control strobes; flush squashes anything not yet committed
    always_comb begin
        w_state_nx = r_state;
        w_launch   = 1'b0;
        w_commit   = 1'b0;
        w_move_ok  = 1'b0;
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                w_move_ok = ~start;
                if (start && !flush) begin
                    w_state_nx = ST_RUN;
                    w_launch   = 1'b1;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nx = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                if (flush) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DONE;
                    w_commit   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Working registers: load on launch, one multiply or divide step per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dbz_pend <= 1'b0;
        end else if (w_launch) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= w_is_div_in ? w_abs_a : w_abs_b;
            r_opb      <= w_is_div_in ? w_abs_b : w_abs_a;
            r_is_div   <= w_is_div_in;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_dbz_pend <= w_is_div_in && (b == '0);
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
                // No borrow means the divisor fits: keep the difference, quotient bit 1
                r_acc <= w_cout ? w_sum[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                r_q   <= {r_q[WIDTH-2:0], w_cout};
            end else begin
                r_acc <= w_sum[WIDTH:1];
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO and the divide-by-zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else if (w_launch) begin
            r_dbz <= 1'b0;
        end else if (w_commit) begin
            r_dbz <= r_dbz_pend;
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_fix[WIDTH-1:0];
            end
        end else if (w_move_ok) begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;
    logic dbz_after_start;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op from IDLE, wait for done (bounded), check latency, return in IDLE
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag);
        int  cyc;
        bit  seen;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dbz_after_start = div_by_zero;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n_done;
        int lat;

        rst = 1'b1; start = 0; op = 0; a = 0; b = 0; flush = 0;
        mthi = 0; mtlo = 0; wdata = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        check("reset_hi",   {32'd0, hi}, 64'd0);
        check("reset_lo",   {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz",  {63'd0, div_by_zero}, 64'd0);

        // Multiplies
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, "multu_2p32");
        check("multu_2p32_hilo", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        check("mult_neg3x7_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
        check("mult_minsq_hilo", {hi, lo}, 64'h4000_0000_0000_0000);

        // Divides: hi = remainder, lo = quotient
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        check("div_neg7by2_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, "div_7byneg2");
        check("div_7byneg2_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'd100, 32'd7, "divu_100by7");
        check("divu_100by7_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        // Divide by zero, then the next start clears the flag
        run_op(2'b10, 32'd5, 32'd0, "divu_by0");
        check("divu_by0_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        check("divu_by0_flag", {63'd0, div_by_zero}, 64'd1);
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, "div_neg5by0");
        check("div_neg5by0_hilo", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
        check("div_neg5by0_flag", {63'd0, div_by_zero}, 64'd1);
        run_op(2'b00, 32'd2, 32'd3, "multu_2x3");
        check("dbz_cleared_at_start", {63'd0, dbz_after_start}, 64'd0);
        check("multu_2x3_hilo", {hi, lo}, 64'h0000_0000_0000_0006);
        check("dbz_clear_final", {63'd0, div_by_zero}, 64'd0);

        // Second start during RUN is ignored: one done, original result
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; lat = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                if (lat == 0) lat = i;
            end
            if (i == 4) begin
                start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        check("restart_done_count", 64'(n_done), 64'd1);
        check("restart_latency", 64'(lat), 64'd33);
        check("restart_hilo", {hi, lo}, 64'h0000_0000_0000_0006);
        check("restart_idle", {63'd0, busy}, 64'd0);

        // Flush mid-RUN: back to IDLE, no done, HI/LO kept
        op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (i == 10) check("flush_busy", {63'd0, busy}, 64'd0);
            flush = (i == 9);
        end
        flush = 1'b0;
        check("flush_no_done", 64'(n_done), 64'd0);
        check("flush_hilo_kept", {hi, lo}, 64'h0000_0000_0000_0006);

        // Flush together with start in IDLE: no launch
        op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_no_launch", {63'd0, busy}, 64'd0);

        // MTHI in IDLE
        mthi = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_idle", {hi, lo}, 64'h0000_1234_0000_0006);

        // start and MTHI together: move dropped; MTLO while busy ignored
        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1; mthi = 1'b1; wdata = 32'h0000_5555;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("start_beats_mthi", {32'd0, hi}, 64'h0000_1234);
        check("busy_in_run", {63'd0, busy}, 64'd1);
        n_done = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (i == 4) check("mtlo_busy_ignored", {32'd0, lo}, 64'h0000_0006);
            mtlo  = (i == 3);
            wdata = 32'h0000_DEAD;
        end
        mtlo = 1'b0;
        check("mtlo_busy_done_count", 64'(n_done), 64'd1);
        check("mtlo_busy_result", {hi, lo}, 64'h0000_0000_0000_0009);

        // Asynchronous reset between edges mid-RUN
        mthi = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clk); #1;
        mthi = 1'b0;
        op = 2'b00; a = 32'd7; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        check("async_rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
